// File: rtl/conv3x3_accumulator_if.sv
// Stream bundle for conv3x3_accumulator: window, kernel and result
// handshakes plus layer-count configuration and the sticky id flag.
interface conv3x3_accumulator_if #(
    parameter int STREAM_DATA_WIDTH = 72,
    parameter int ACC_WIDTH         = 32
);
    logic [9:0]                   no_of_input_layers;
    logic [STREAM_DATA_WIDTH-1:0] in_data;
    logic [9:0]                   in_id;
    logic                         in_valid;
    logic                         in_rdy;
    logic [STREAM_DATA_WIDTH-1:0] w_data;
    logic                         w_valid;
    logic                         w_rdy;
    logic [ACC_WIDTH-1:0]         out_data;
    logic                         out_valid;
    logic                         out_rdy;
    logic                         id_error;

    modport slave (
        input  no_of_input_layers, in_data, in_id, in_valid,
        input  w_data, w_valid, out_rdy,
        output in_rdy, w_rdy, out_data, out_valid, id_error
    );

    modport master (
        output no_of_input_layers, in_data, in_id, in_valid,
        output w_data, w_valid, out_rdy,
        input  in_rdy, w_rdy, out_data, out_valid, id_error
    );
endinterface

// File: rtl/conv3x3_accumulator.sv
// 3x3 window x kernel dot product accumulated over N input layers.
// Ports: clk, rst_n (async low), bus (slave: window/kernel in, result out).
module conv3x3_accumulator #(
    parameter int STREAM_DATA_WIDTH = 72,
    parameter int ACC_WIDTH         = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    conv3x3_accumulator_if.slave bus
);
    localparam int LANES = STREAM_DATA_WIDTH / 8;

    logic adv;
    logic fire;
    logic out_valid;
    logic [ACC_WIDTH-1:0] out_data;
    logic id_error;

    logic [9:0] lcnt;
    logic [9:0] n_reg;
    logic [9:0] n_cur;
    logic       first_cur;
    logic       last_cur;

    logic signed [16:0] prod [LANES];
    logic signed [16:0] s1_p [LANES];
    logic               s1_valid;
    logic               s1_last;
    logic               s1_first;

    logic signed [20:0] sum;
    logic signed [20:0] s2_sum;
    logic               s2_valid;
    logic               s2_last;
    logic               s2_first;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_next;

    assign adv  = !out_valid | bus.out_rdy;
    assign fire = bus.in_valid & bus.w_valid & adv;

    assign bus.in_rdy    = bus.w_valid & adv;
    assign bus.w_rdy     = bus.in_valid & adv;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.id_error  = id_error;

    // Group size is sampled only at layer 0; later changes are ignored.
    always_comb begin
        n_cur = n_reg;
        if (lcnt == 10'd0) begin
            n_cur = (bus.no_of_input_layers == 10'd0) ?
                    10'd1 : bus.no_of_input_layers;
        end
        first_cur = (lcnt == 10'd0);
        last_cur  = (lcnt == n_cur - 10'd1);
    end

    // Pixels are unsigned, kernel taps signed: widen both to 17 bits.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod[k] = $signed({8'b0, bus.in_data[8*k +: 8]}) *
                      $signed({{9{bus.w_data[8*k+7]}},
                               bus.w_data[8*k +: 8]});
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            sum = sum + {{4{s1_p[k][16]}}, s1_p[k]};
        end
    end

    assign acc_next = (s2_first ? '0 : acc) +
                      {{(ACC_WIDTH-21){s2_sum[20]}}, s2_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt     <= '0;
            n_reg    <= 10'd1;
            id_error <= 1'b0;
        end else if (fire) begin
            lcnt <= last_cur ? 10'd0 : lcnt + 10'd1;
            if (first_cur) n_reg <= n_cur;
            if (bus.in_id != lcnt) id_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) s1_p[k] <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_first <= 1'b0;
        end else if (adv) begin
            s1_valid <= fire;
            if (fire) begin
                s1_p     <= prod;
                s1_last  <= last_cur;
                s1_first <= first_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum   <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_first <= 1'b0;
        end else if (adv) begin
            s2_sum   <= sum;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_first <= s1_first;
        end
    end

    // adv high means the held result (if any) is consumed this cycle,
    // so out_valid simply follows whether a group completes now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid & s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    out_data <= acc_next;
                    acc      <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_accumulator.sv
// Randomized self-checking bench for conv3x3_accumulator.
// Reference model: per-layer dot products summed per group of N.
module tb_conv3x3_accumulator;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   got_q[$];
    int   got_cyc[$];
    int   exp_q[$];
    int   m_cnt;
    int   m_n;
    longint m_acc;
    bit   rnd_on;

    conv3x3_accumulator_if #(.STREAM_DATA_WIDTH(72), .ACC_WIDTH(32)) bus ();

    conv3x3_accumulator #(.STREAM_DATA_WIDTH(72), .ACC_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_rdy) begin
            got_q.push_back(int'($signed(bus.out_data)));
            got_cyc.push_back(cyc);
        end
    end

    function automatic int dot(logic [71:0] p, logic [71:0] w);
        int s = 0;
        for (int k = 0; k < 9; k++)
            s += int'(p[8*k +: 8]) * int'($signed(w[8*k +: 8]));
        return s;
    endfunction

    function automatic logic [71:0] rand72();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[71:0];
    endfunction

    task automatic model_beat(logic [71:0] p, logic [71:0] w);
        if (m_cnt == 0) begin
            m_n = (bus.no_of_input_layers == 10'd0) ?
                  1 : int'(bus.no_of_input_layers);
            m_acc = 0;
        end
        m_acc += dot(p, w);
        m_cnt++;
        if (m_cnt == m_n) begin
            exp_q.push_back(int'(m_acc));
            m_cnt = 0;
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.w_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_cnt = 0;
        m_acc = 0;
        clear_q();
    endtask

    task automatic send_beat(logic [71:0] p, logic [71:0] w,
                             logic [9:0] id, output int t_fire);
        int n = 0;
        bus.in_data  = p;
        bus.w_data   = w;
        bus.in_id    = id;
        bus.in_valid = 1'b1;
        bus.w_valid  = 1'b1;
        t_fire = -1;
        forever begin
            @(negedge clk);
            if (bus.in_rdy && bus.w_rdy) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout got no transfer exp transfer");
                bus.in_valid = 1'b0;
                bus.w_valid  = 1'b0;
                return;
            end
        end
        t_fire = cyc;
        model_beat(p, w);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.w_valid  = 1'b0;
    endtask

    task automatic wait_outputs(int n, output bit ok);
        int c = 0;
        ok = 1'b1;
        while (got_q.size() < n) begin
            @(posedge clk);
            c++;
            if (c > 300) begin
                ok = 1'b0;
                return;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_out_data got %0h exp 0", bus.out_data);
        end
        checks++;
        if (bus.id_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_id_error got %0b exp 0", bus.id_error);
        end
        checks++;
        if ({bus.in_rdy, bus.w_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_rdy got %b exp 00", {bus.in_rdy, bus.w_rdy});
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL lone_in_rdy got %0b exp 0", bus.in_rdy);
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL lone_no_output got %0d exp 0", got_q.size());
        end
        clear_q();
    endtask

    task automatic test_single();
        int t;
        bit ok;
        bus.no_of_input_layers = 10'd1;
        send_beat({9{8'h01}}, {9{8'h02}}, 10'd0, t);
        wait_outputs(1, ok);
        checks++;
        if (!ok || got_q[0] !== 18) begin
            errors++;
            $display("FAIL single_value got %0d exp 18",
                     ok ? got_q[0] : -1);
        end
        checks++;
        if (!ok || got_cyc[0] - t !== 3) begin
            errors++;
            $display("FAIL single_latency got %0d exp 3",
                     ok ? got_cyc[0] - t : -1);
        end
        checks++;
        if (bus.id_error !== 1'b0) begin
            errors++;
            $display("FAIL single_id_error got %0b exp 0", bus.id_error);
        end
        clear_q();
    endtask

    task automatic test_max();
        int t;
        bit ok;
        bus.no_of_input_layers = 10'd3;
        for (int i = 0; i < 3; i++)
            send_beat({9{8'hFF}}, {9{8'h80}}, 10'(i), t);
        @(negedge clk);
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL max_early got %0d outputs exp 0", got_q.size());
        end
        wait_outputs(1, ok);
        checks++;
        if (!ok || got_q[0] !== 32'hFFF28D80) begin
            errors++;
            $display("FAIL max_value got %0d exp -881280",
                     ok ? got_q[0] : -1);
        end
        checks++;
        if (!ok || got_cyc[0] - t !== 3) begin
            errors++;
            $display("FAIL max_latency got %0d exp 3",
                     ok ? got_cyc[0] - t : -1);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() !== 1) begin
            errors++;
            $display("FAIL max_count got %0d exp 1", got_q.size());
        end
        clear_q();
    endtask

    task automatic test_back_to_back_stall();
        int t;
        bit ok;
        logic [71:0] p5;
        logic [71:0] w5;
        bus.no_of_input_layers = 10'd2;
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 4; i++)
            send_beat(rand72(), rand72(), 10'(m_cnt), t);
        p5 = rand72();
        w5 = rand72();
        bus.in_data  = p5;
        bus.w_data   = w5;
        bus.in_id    = 10'(m_cnt);
        bus.in_valid = 1'b1;
        bus.w_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 ||
                int'($signed(bus.out_data)) !== exp_q[0]) begin
                errors++;
                $display("FAIL stall_hold got %0b/%0d exp 1/%0d",
                         bus.out_valid, $signed(bus.out_data), exp_q[0]);
            end
            checks++;
            if (bus.in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_rdy got %0b exp 0", bus.in_rdy);
            end
        end
        @(posedge clk); #1;
        bus.out_rdy = 1'b1;
        send_beat(p5, w5, 10'(m_cnt), t);
        send_beat(rand72(), rand72(), 10'(m_cnt), t);
        wait_outputs(3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_count got %0d exp 3", got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_order[%0d] got %0d exp %0d", i,
                         i < got_q.size() ? got_q[i] : -1, exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_id_error();
        int t;
        bit ok;
        logic [71:0] p0;
        logic [71:0] w0;
        do_reset();
        bus.no_of_input_layers = 10'd2;
        p0 = rand72();
        w0 = rand72();
        send_beat(p0, w0, 10'd0, t);
        @(negedge clk);
        checks++;
        if (bus.id_error !== 1'b0) begin
            errors++;
            $display("FAIL id_first got %0b exp 0", bus.id_error);
        end
        send_beat(rand72(), rand72(), 10'd0, t);
        @(negedge clk);
        checks++;
        if (bus.id_error !== 1'b1) begin
            errors++;
            $display("FAIL id_rise got %0b exp 1", bus.id_error);
        end
        wait_outputs(1, ok);
        checks++;
        if (!ok || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL id_result got %0d exp %0d",
                     ok ? got_q[0] : -1, exp_q[0]);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.id_error !== 1'b1) begin
            errors++;
            $display("FAIL id_sticky got %0b exp 1", bus.id_error);
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        int t;
        bit ok;
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.id_error !== 1'b0) begin
            errors++;
            $display("FAIL rm_id_clear got %0b exp 0", bus.id_error);
        end
        bus.no_of_input_layers = 10'd3;
        send_beat(rand72(), rand72(), 10'd0, t);
        send_beat(rand72(), rand72(), 10'd1, t);
        repeat (4) @(posedge clk);
        do_reset();
        bus.no_of_input_layers = 10'd1;
        send_beat({9{8'h02}}, {9{8'h03}}, 10'd0, t);
        wait_outputs(1, ok);
        checks++;
        if (!ok || got_q[0] !== 54) begin
            errors++;
            $display("FAIL rm_value got %0d exp 54", ok ? got_q[0] : -1);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() !== 1 || bus.id_error !== 1'b0) begin
            errors++;
            $display("FAIL rm_clean got %0d/%0b exp 1/0",
                     got_q.size(), bus.id_error);
        end
        clear_q();
    endtask

    task automatic test_toggle();
        bit ok;
        bit done;
        logic [71:0] p;
        logic [71:0] w;
        bus.no_of_input_layers = 10'd3;
        for (int b = 0; b < 6; b++) begin
            p = rand72();
            w = rand72();
            bus.in_data  = p;
            bus.in_id    = 10'(m_cnt);
            bus.in_valid = 1'b1;
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                bus.w_valid = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
                bus.w_data  = bus.w_valid ? w : rand72();
                @(negedge clk);
                checks++;
                if (bus.in_rdy !== bus.w_valid || bus.w_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL toggle_rdy got %0b%0b exp %0b1",
                             bus.in_rdy, bus.w_rdy, bus.w_valid);
                end
                if (bus.w_valid) begin
                    model_beat(p, w);
                    done = 1'b1;
                end
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
            bus.w_valid  = 1'b0;
        end
        wait_outputs(2, ok);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL toggle_result[%0d] got %0d exp %0d", i,
                         i < got_q.size() ? got_q[i] : -1, exp_q[i]);
            end
        end
        checks++;
        if (bus.id_error !== 1'b0) begin
            errors++;
            $display("FAIL toggle_lcnt got id_error %0b exp 0",
                     bus.id_error);
        end
        clear_q();
    endtask

    task automatic test_random();
        int t;
        bit ok;
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                bus.out_rdy = 1'($urandom_range(0, 1));
            end
        join_none
        for (int b = 0; b < 60; b++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            bus.no_of_input_layers = 10'($urandom_range(0, 4));
            send_beat(rand72(), rand72(), 10'(m_cnt), t);
        end
        while (m_cnt != 0)
            send_beat(rand72(), rand72(), 10'(m_cnt), t);
        rnd_on = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.out_rdy = 1'b1;
        wait_outputs(exp_q.size(), ok);
        checks++;
        if (!ok || got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d exp %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_result[%0d] got %0d exp %0d", i,
                         i < got_q.size() ? got_q[i] : -1, exp_q[i]);
            end
        end
        checks++;
        if (bus.id_error !== 1'b0) begin
            errors++;
            $display("FAIL rand_id_error got %0b exp 0", bus.id_error);
        end
        clear_q();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        m_cnt  = 0;
        m_n    = 1;
        m_acc  = 0;
        rnd_on = 1'b0;
        rst_n  = 1'b0;
        bus.no_of_input_layers = 10'd1;
        bus.in_data  = '0;
        bus.in_id    = '0;
        bus.in_valid = 1'b0;
        bus.w_data   = '0;
        bus.w_valid  = 1'b0;
        bus.out_rdy  = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_max();
        test_back_to_back_stall();
        test_id_error();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
